// File: rtl/sayeh_sr_pkg.sv
// Shared constants for the SAYEH-style status register with shadow stack.
package sayeh_sr_pkg;

    // Architectural flag positions in the live register
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;

    // Default geometry
    localparam int unsigned NFLAGS_DEF = 2;
    localparam int unsigned DEPTH_DEF  = 4;

    // Width of the stack level counter for the default depth
    localparam int unsigned LVL_W = $clog2(DEPTH_DEF + 1);

    // Per-bit mask update: set wins over clear, untouched bits hold
    function automatic logic [31:0] apply_masks(
        input logic [31:0] cur,
        input logic [31:0] set_m,
        input logic [31:0] clr_m
    );
        return set_m | (cur & ~clr_m);
    endfunction

endpackage

// File: rtl/sr_lifo.sv
// LIFO shadow storage with level counter and registered full/empty decode.
// Callers present only effective operations: push when not full, pop or
// exchange when not empty. The guards below are a second line of defence.
module sr_lifo
    import sayeh_sr_pkg::*;
#(
    parameter int unsigned WIDTH = NFLAGS_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         exchange,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [LEVEL_W-1:0] r_level;
    logic               r_full;
    logic               r_empty;

    logic [LEVEL_W-1:0] w_level_nxt;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_top_idx;
    logic               w_do_push;
    logic               w_do_pop;
    logic               w_do_exch;

    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;
    assign w_do_exch = exchange && !r_empty;

    assign w_wr_idx  = IDX_W'(r_level);
    assign w_top_idx = IDX_W'(r_level - LEVEL_W'(1));

    // Next level: exchange leaves the count untouched
    always_comb begin
        w_level_nxt = r_level;
        if (w_do_push) begin
            w_level_nxt = r_level + LEVEL_W'(1);
        end else if (w_do_pop) begin
            w_level_nxt = r_level - LEVEL_W'(1);
        end
    end

    // Level counter and its full/empty decode, registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LEVEL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Storage array; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_do_push) begin
                r_mem[w_wr_idx] <= wdata;
            end else if (w_do_exch) begin
                r_mem[w_top_idx] <= wdata;
            end
        end
    end

    assign rdata = r_empty ? '0 : r_mem[w_top_idx];
    assign level = r_level;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/status_register_stack.sv
// Live status flag register with set/clear masks, parallel load and a
// LIFO shadow stack for save/restore around interrupts and calls.
module status_register_stack
    import sayeh_sr_pkg::*;
#(
    parameter int unsigned NFLAGS = NFLAGS_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         SRload,
    input  logic [NFLAGS-1:0]            flag_in,
    input  logic [NFLAGS-1:0]            set_mask,
    input  logic [NFLAGS-1:0]            clr_mask,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         err_clr,
    output logic [NFLAGS-1:0]            flags_out,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    logic [NFLAGS-1:0] r_flags;
    logic              r_overflow;
    logic              r_underflow;

    logic [NFLAGS-1:0] w_flags_nxt;
    logic [NFLAGS-1:0] w_masked;
    logic [NFLAGS-1:0] w_stack_top;
    logic              w_full;
    logic              w_empty;
    logic              w_push_eff;
    logic              w_pop_eff;
    logic              w_exch_eff;
    logic              w_ovf_evt;
    logic              w_unf_evt;
    logic              w_ovf_nxt;
    logic              w_unf_nxt;

    // Resolve push/pop requests against the current stack occupancy.
    // push+pop on an empty stack degrades to a plain push.
    assign w_push_eff = push && !w_full && (!pop || w_empty);
    assign w_pop_eff  = pop && !push && !w_empty;
    assign w_exch_eff = push && pop && !w_empty;
    assign w_ovf_evt  = push && !pop && w_full;
    assign w_unf_evt  = pop && !push && w_empty;

    sr_lifo #(
        .WIDTH (NFLAGS),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push_eff),
        .pop      (w_pop_eff),
        .exchange (w_exch_eff),
        .wdata    (r_flags),
        .rdata    (w_stack_top),
        .level    (level),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign w_masked = NFLAGS'(apply_masks(32'(r_flags), 32'(set_mask), 32'(clr_mask)));

    // Live register next value: restore from stack, then load, then masks
    always_comb begin
        w_flags_nxt = r_flags;
        if (w_pop_eff || w_exch_eff) begin
            w_flags_nxt = w_stack_top;
        end else if (SRload) begin
            w_flags_nxt = flag_in;
        end else begin
            w_flags_nxt = w_masked;
        end
    end

    // Sticky error next value: a new event beats a clear in the same cycle
    always_comb begin
        w_ovf_nxt = r_overflow;
        w_unf_nxt = r_underflow;
        if (err_clr) begin
            w_ovf_nxt = 1'b0;
            w_unf_nxt = 1'b0;
        end
        if (w_ovf_evt) begin
            w_ovf_nxt = 1'b1;
        end
        if (w_unf_evt) begin
            w_unf_nxt = 1'b1;
        end
    end

    // Live flags and sticky errors
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_flags     <= w_flags_nxt;
            r_overflow  <= w_ovf_nxt;
            r_underflow <= w_unf_nxt;
        end
    end

    assign flags_out = r_flags;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
